// File: rtl/evt_counter_deserializer.sv
// rtl/evt_counter_deserializer.sv - rebuilds event-counter serial readout words and keeps them in a readable shadow bank
// Optional even-parity bit after each data word: define RX_PARITY_EN.
module evt_counter_deserializer #(
  parameter int CNT_W   = 8,
  parameter int LAST_CH = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             sl_in,
  input  logic [3:0]       addr_in,
  input  logic             ovf_global_in,
  input  logic             ovf_rtc_in,
  input  logic             err_clr,
  input  logic [3:0]       rd_addr,
  output logic             word_valid,
  output logic [3:0]       word_chan,
  output logic [CNT_W-1:0] word_data,
  output logic             word_ovf,
  output logic             frame_done,
  output logic             rtc_tick,
  output logic             busy,
  output logic             err_sync,
  output logic             err_parity,
  output logic [CNT_W-1:0] rd_data
);

  localparam int BC_W = $clog2(CNT_W + 1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(CNT_W - 1);

  // Without parity the last data bit goes straight to the output word, so the
  // shift register only needs to hold the first CNT_W-1 bits.
`ifdef RX_PARITY_EN
  localparam int SH_W = CNT_W;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
`else
  localparam int SH_W = CNT_W - 1;
  typedef enum logic [0:0] {S_IDLE, S_SHIFT} state_t;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_chan;
  logic [SH_W-1:0]  r_shift;
  logic [BC_W-1:0]  r_bit_cnt;
  logic             r_word_valid;
  logic [3:0]       r_word_chan;
  logic [CNT_W-1:0] r_word_data;
  logic             r_word_ovf;
  logic             r_frame_done;
  logic             r_err_sync;
  logic             r_rtc_prev;
  logic [CNT_W-1:0] r_rd_data;
  logic [CNT_W-1:0] r_bank [1:LAST_CH];

  logic             w_addr_ok;
  logic             w_rd_ok;
  logic             w_start;
  logic             w_shift;
  logic             w_sync_err;
  logic             w_deliver;
  logic [CNT_W-1:0] w_word;
  logic             w_ovf;

`ifdef RX_PARITY_EN
  logic             r_ovf_cap;
  logic             r_err_parity;
  logic             w_last;
  logic             w_par_err;
`endif

  assign w_addr_ok = (addr_in != 4'd0) && ({1'b0, addr_in} <= 5'(LAST_CH));
  assign w_rd_ok   = (rd_addr != 4'd0) && ({1'b0, rd_addr} <= 5'(LAST_CH));

`ifdef RX_PARITY_EN
  assign w_word = r_shift;
  assign w_ovf  = r_ovf_cap;
`else
  assign w_word = {r_shift, serial_in};
  assign w_ovf  = ovf_global_in;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_sync_err  = 1'b0;
    w_deliver   = 1'b0;
`ifdef RX_PARITY_EN
    w_last      = 1'b0;
    w_par_err   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (sl_in) begin
          if (w_addr_ok) begin
            w_start     = 1'b1;
            w_state_nxt = S_SHIFT;
          end else begin
            w_sync_err  = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        // A strobe inside a word aborts it and is itself a fresh start.
        if (sl_in) begin
          w_sync_err = 1'b1;
          if (w_addr_ok) begin
            w_start     = 1'b1;
            w_state_nxt = S_SHIFT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (addr_in != r_chan) begin
          w_sync_err  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_shift = 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
`ifdef RX_PARITY_EN
            w_last      = 1'b1;
            w_state_nxt = S_PARITY;
`else
            w_deliver   = 1'b1;
            w_state_nxt = S_IDLE;
`endif
          end
        end
      end
`ifdef RX_PARITY_EN
      S_PARITY: begin
        if (sl_in) begin
          w_sync_err = 1'b1;
          if (w_addr_ok) begin
            w_start     = 1'b1;
            w_state_nxt = S_SHIFT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (addr_in != r_chan) begin
          w_sync_err  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_IDLE;
          if (^{r_shift, serial_in}) begin
            w_par_err = 1'b1;
          end else begin
            w_deliver = 1'b1;
          end
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_chan       <= 4'd0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_word_valid <= 1'b0;
      r_word_chan  <= 4'd0;
      r_word_data  <= '0;
      r_word_ovf   <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_sync   <= 1'b0;
      r_rtc_prev   <= 1'b0;
      r_rd_data    <= '0;
      for (int i = 1; i <= LAST_CH; i++) begin
        r_bank[i] <= '0;
      end
`ifdef RX_PARITY_EN
      r_ovf_cap    <= 1'b0;
      r_err_parity <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_word_valid <= w_deliver;
      r_frame_done <= w_deliver && (r_chan == 4'(LAST_CH));
      r_rtc_prev   <= ovf_rtc_in;
      r_err_sync   <= (r_err_sync & ~err_clr) | w_sync_err;

      if (w_start) begin
        r_chan    <= addr_in;
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end else if (w_shift) begin
        r_shift   <= {r_shift[SH_W-2:0], serial_in};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      if (w_deliver) begin
        r_word_chan <= r_chan;
        r_word_data <= w_word;
        r_word_ovf  <= w_ovf;
      end

      // Bank update trails the output pulse by one edge, so a same-cycle read sees the old entry.
      if (r_word_valid) begin
        r_bank[r_word_chan] <= r_word_data;
      end
      r_rd_data <= w_rd_ok ? r_bank[rd_addr] : '0;

`ifdef RX_PARITY_EN
      if (w_last) begin
        r_ovf_cap <= ovf_global_in;
      end
      r_err_parity <= (r_err_parity & ~err_clr) | w_par_err;
`endif
    end
  end

  assign word_valid = r_word_valid;
  assign word_chan  = r_word_chan;
  assign word_data  = r_word_data;
  assign word_ovf   = r_word_ovf;
  assign frame_done = r_frame_done;
  assign rtc_tick   = ovf_rtc_in & ~r_rtc_prev & ~reset;
  assign busy       = (r_state != S_IDLE);
  assign err_sync   = r_err_sync;
  assign rd_data    = r_rd_data;
`ifdef RX_PARITY_EN
  assign err_parity = r_err_parity;
`else
  assign err_parity = 1'b0;
`endif

endmodule

// File: tb/tb_evt_counter_deserializer.sv
// tb/tb_evt_counter_deserializer.sv - scoreboard bench for evt_counter_deserializer
module tb_evt_counter_deserializer;

  localparam int CNT_W   = 8;
  localparam int LAST_CH = 15;
`ifdef RX_PARITY_EN
  localparam int LAT = CNT_W + 1;
`else
  localparam int LAT = CNT_W;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             serial_in = 1'b0;
  logic             sl_in = 1'b0;
  logic [3:0]       addr_in = 4'd0;
  logic             ovf_global_in = 1'b0;
  logic             ovf_rtc_in = 1'b0;
  logic             err_clr = 1'b0;
  logic [3:0]       rd_addr = 4'd0;
  logic             word_valid;
  logic [3:0]       word_chan;
  logic [CNT_W-1:0] word_data;
  logic             word_ovf;
  logic             frame_done;
  logic             rtc_tick;
  logic             busy;
  logic             err_sync;
  logic             err_parity;
  logic [CNT_W-1:0] rd_data;

  evt_counter_deserializer #(.CNT_W(CNT_W), .LAST_CH(LAST_CH)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in), .sl_in(sl_in),
    .addr_in(addr_in), .ovf_global_in(ovf_global_in), .ovf_rtc_in(ovf_rtc_in),
    .err_clr(err_clr), .rd_addr(rd_addr), .word_valid(word_valid),
    .word_chan(word_chan), .word_data(word_data), .word_ovf(word_ovf),
    .frame_done(frame_done), .rtc_tick(rtc_tick), .busy(busy),
    .err_sync(err_sync), .err_parity(err_parity), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       ch;
    logic [CNT_W-1:0] data;
    logic             ovf;
    logic             fd;
    int               cyc;
  } exp_t;

  exp_t             exp_q[$];
  logic [CNT_W-1:0] bank_m [0:15];
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  bit               exp_err_sync = 1'b0;
  bit               exp_err_par = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every delivered word must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (word_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got chan %0d data %0h, expected no word", word_chan, word_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word_chan", 32'(word_chan), 32'(e.ch));
          chk("word_data", 32'(word_data), 32'(e.data));
          chk("word_ovf", 32'(word_ovf), 32'(e.ovf));
          chk("frame_done", 32'(frame_done), 32'(e.fd));
          chk("valid_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else if (frame_done) begin
        checks++;
        errors++;
        $display("FAIL lone_frame_done: got 1 expected 0");
      end
    end
  end

  // Full word, SL through last data (and parity) bit; returns in the word_valid cycle.
  task automatic send_word(input logic [3:0] ch, input logic [CNT_W-1:0] data,
                           input logic ovf, input bit bad_par);
    bit deliver = 1'b1;
`ifdef RX_PARITY_EN
    deliver = !bad_par;
`endif
    if (deliver) begin
      exp_q.push_back('{ch, data, ovf, (ch == 4'(LAST_CH)), cyc + 1 + LAT});
      bank_m[ch] = data;
    end else begin
      exp_err_par = 1'b1;
    end
    sl_in = 1'b1;
    addr_in = ch;
    serial_in = 1'($urandom);
    tick();
    sl_in = 1'b0;
    for (int i = CNT_W - 1; i >= 0; i--) begin
      serial_in = data[i];
      ovf_global_in = (i == 0) ? ovf : 1'($urandom);
      tick();
    end
    ovf_global_in = 1'b0;
`ifdef RX_PARITY_EN
    serial_in = (^data) ^ bad_par;
    tick();
`endif
    serial_in = 1'b0;
  endtask

  // Starts a word and leaves it unfinished after nbits bits.
  task automatic partial_word(input logic [3:0] ch, input int nbits);
    sl_in = 1'b1;
    addr_in = ch;
    tick();
    sl_in = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      serial_in = 1'($urandom);
      tick();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      serial_in = 1'($urandom);
      ovf_global_in = 1'($urandom);
      tick();
    end
    serial_in = 1'b0;
    ovf_global_in = 1'b0;
  endtask

  task automatic check_bank();
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      tick();
      chk($sformatf("rd_data[%0d]", a), 32'(rd_data),
          (a >= 1 && a <= LAST_CH) ? 32'(bank_m[a]) : 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

  initial begin
    logic [CNT_W-1:0] old_v;
    for (int i = 0; i < 16; i++) bank_m[i] = '0;

    // Reset state
    tick(); tick();
    @(negedge clk);
    chk("rst_word_valid", 32'(word_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err_sync", 32'(err_sync), 0);
    chk("rst_err_parity", 32'(err_parity), 0);
    chk("rst_word_data", 32'(word_data), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    tick();
    reset = 1'b0;
    idle(2);

    // Single word, then read back
    send_word(4'd3, 8'hA5, 1'b0, 1'b0);
    chk("busy_after_word", 32'(busy), 0);
    idle(1);
    rd_addr = 4'd3;
    tick();
    chk("rd_single", 32'(rd_data), 32'hA5);

    // Full back-to-back frame, overflow on channel 7 only
    for (int ch = 1; ch <= LAST_CH; ch++) begin
      send_word(4'(ch), 8'(8'h10 + ch), (ch == 7), 1'b0);
    end
    idle(2);
    check_bank();
    chk("no_err_after_frame", 32'(err_sync), 0);

    // SL repeated after 4 bits of channel 5, then channel 6
    partial_word(4'd5, 4);
    chk("busy_mid_word", 32'(busy), 1);
    send_word(4'd6, 8'h3C, 1'b1, 1'b0);
    exp_err_sync = 1'b1;
    idle(1);
    chk("err_sync_restart", 32'(err_sync), 32'(exp_err_sync));

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_err_sync = 1'b0;
    chk("err_clr_alone", 32'(err_sync), 0);

    // SL landing on the last data-bit cycle
    partial_word(4'd4, CNT_W - 1);
    send_word(4'd8, 8'hC3, 1'b0, 1'b0);
    idle(1);
    chk("err_sync_last_bit", 32'(err_sync), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Address change mid-word
    partial_word(4'd2, 3);
    addr_in = 4'd9;
    tick();
    chk("addr_change_busy", 32'(busy), 0);
    chk("addr_change_err", 32'(err_sync), 1);
    idle(CNT_W + 2);

    // SL with addr 0, together with err_clr
    err_clr = 1'b1;
    sl_in = 1'b1;
    addr_in = 4'd0;
    tick();
    sl_in = 1'b0;
    err_clr = 1'b0;
    chk("err_clr_vs_new_err", 32'(err_sync), 1);
    chk("addr0_busy", 32'(busy), 0);
    idle(CNT_W + 2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr_final", 32'(err_sync), 0);

    // RTC edge detection
    ovf_rtc_in = 1'b1;
    @(negedge clk);
    chk("rtc_first", 32'(rtc_tick), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("rtc_hold", 32'(rtc_tick), 0);
    end
    tick();
    ovf_rtc_in = 1'b0;
    idle(1);

    // Read/write collision on the same entry
    old_v = bank_m[3];
    send_word(4'd3, 8'h5A, 1'b0, 1'b0);
    rd_addr = 4'd3;
    tick();
    chk("collision_old", 32'(rd_data), 32'(old_v));
    tick();
    chk("collision_new", 32'(rd_data), 32'h5A);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = $urandom_range(0, 7);
      if (kind == 6) begin
        partial_word(4'($urandom_range(1, LAST_CH)), $urandom_range(0, LAT - 1));
        exp_err_sync = 1'b1;
        send_word(4'($urandom_range(1, LAST_CH)), 8'($urandom), 1'($urandom), 1'b0);
      end else if (kind == 7) begin
        idle($urandom_range(1, 3));
      end else begin
        send_word(4'($urandom_range(1, LAST_CH)), 8'($urandom), 1'($urandom), 1'b0);
      end
    end
    idle(2);
    chk("err_sync_random", 32'(err_sync), 32'(exp_err_sync));
    check_bank();

`ifdef RX_PARITY_EN
    // Bad parity: no word, bank untouched
    send_word(4'd5, 8'hA5, 1'b0, 1'b1);
    idle(2);
    chk("err_parity_set", 32'(err_parity), 32'(exp_err_par));
    check_bank();
`else
    chk("err_parity_tied", 32'(err_parity), 0);
`endif

    // Reset in the middle of a word
    partial_word(4'd9, 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) bank_m[i] = '0;
    exp_err_sync = 1'b0;
    exp_err_par = 1'b0;
    idle(CNT_W + 2);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_err_sync", 32'(err_sync), 0);
    chk("reset_err_parity", 32'(err_parity), 0);
    check_bank();

    idle(3);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/evt_counter_deserializer.md
Name: evt_counter_deserializer

Overview:
Receive-side counterpart of the 15-channel event counter. Captures the counter's serial readout stream (serial data, SL load strobe, 4-bit channel address, overflow flags) and rebuilds each channel's count word. Each word is presented on a valid-strobed output and stored in a 15-entry shadow bank, readable by address. Sits on the test/acquisition side (FPGA or companion tile), clocked synchronously with the counter.

Parameters:
CNT_W, 8, bits per channel count word; serial order is MSB first.
LAST_CH, 15, highest channel index; a completed word for this channel marks end of frame.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
serial_in  input  1  serial count data, one bit per clk.
sl_in  input  1  load strobe; high for one cycle marks the start of a word.
addr_in  input  4  channel index of the current word (valid range 1..LAST_CH).
ovf_global_in  input  1  counter global overflow flag.
ovf_rtc_in  input  1  RTC overflow flag.
err_clr  input  1  clears the sticky error flags.
rd_addr  input  4  shadow bank read address.
word_valid  output  1  one-cycle pulse: word_chan, word_data and word_ovf are valid.
word_chan  output  4  channel index of the delivered word.
word_data  output  CNT_W  reconstructed count.
word_ovf  output  1  ovf_global_in sampled on the last data bit.
frame_done  output  1  one-cycle pulse, coincident with word_valid for channel LAST_CH.
rtc_tick  output  1  one-cycle pulse on each 0->1 transition of ovf_rtc_in.
busy  output  1  high while in SHIFT or PARITY.
err_sync  output  1  sticky framing error.
err_parity  output  1  sticky parity error; stays 0 unless RX_PARITY_EN is defined.
rd_data  output  CNT_W  bank[rd_addr], registered, 1-cycle latency.

Behaviour:
- Reset: every output is 0, all bank entries are 0, FSM is in IDLE, bit counter is 0, and the internal ovf_rtc_in history register is 0.
- FSM states: IDLE, SHIFT, PARITY (PARITY exists only with the macro).
- IDLE, sl_in=1, addr_in in 1..LAST_CH: latch addr_in into word_chan_r, clear the shift register, go to SHIFT.
- IDLE, sl_in=1, addr_in=0 or addr_in>LAST_CH: set err_sync and stay in IDLE.
- IDLE, sl_in=0: all other inputs are ignored.
- SHIFT, each cycle: shift serial_in into the LSB and increment the bit counter.
- Timing: SL sampled at cycle t, data bits sampled at t+1..t+CNT_W.
- After bit CNT_W:
  - without the macro, word_valid pulses at t+CNT_W+1 and the FSM returns to IDLE;
  - word_ovf = ovf_global_in sampled at t+CNT_W.
- Back-to-back words are legal: sl_in may be high in the first cycle after the last data bit (or after the parity bit).
- sl_in=1 during SHIFT, including on the last-bit cycle:
  - abort the current word and set err_sync;
  - no word_valid and no bank write;
  - treat that cycle as a new start, applying the IDLE rules above.
- addr_in different from the latched value during SHIFT: abort, set err_sync, return to IDLE with no output.
- word_valid cycle: bank[word_chan] <= word_data. frame_done pulses in the same cycle when word_chan = LAST_CH.
- word_chan, word_data and word_ovf hold their values until the next word_valid.
- rd_data is registered bank[rd_addr]:
  - rd_addr=0 or rd_addr>LAST_CH returns 0;
  - a read and a write to the same entry in the same cycle returns the old value.
- rtc_tick is independent of the FSM and is also active in IDLE.
- err_clr=1 clears err_sync and err_parity. If a new error occurs in the same cycle, the error wins and the flag stays 1.
- Reset asserted mid-word: the word is discarded immediately and everything returns to reset values.

Optional Feature:
RX_PARITY_EN
- Defined: one even-parity bit follows the last data bit, sampled at t+CNT_W+1 in state PARITY. The check is over the CNT_W data bits plus the parity bit.
  - Match: word_valid pulses at t+CNT_W+2.
  - Mismatch: set err_parity; no word_valid and no bank write.
  - sl_in or addr_in violations in PARITY are handled exactly as in SHIFT.
- Undefined: no PARITY state, word_valid at t+CNT_W+1, err_parity tied to 0.

Test Plan:
All scenarios use CNT_W=8, LAST_CH=15, macro undefined unless stated.
- Single word: SL with addr=3, bits 1010_0101 -> word_valid exactly 9 cycles after SL, word_chan=3, word_data=0xA5; then rd_addr=3 gives rd_data=0xA5 one cycle later.
- Full frame: channels 1..15 back-to-back, data = 0x10+ch, ovf_global_in=1 during channel 7 -> 15 word_valid pulses, word_ovf=1 only for channel 7, frame_done only with channel 15, all bank entries match.
- Framing errors:
  - SL repeated after 4 bits of channel 5, then a full channel 6 word -> err_sync=1, no channel-5 output, channel 6 delivered correctly.
  - addr change mid-word -> err_sync=1, FSM returns to IDLE.
  - SL with addr=0 -> err_sync=1, no output.
- Error clear and reset: err_clr together with a new error -> err_sync stays 1. err_clr alone -> err_sync=0. Reset during SHIFT -> no word_valid, bank reads 0.
- RTC: ovf_rtc_in held high for 5 cycles -> exactly one rtc_tick, on the first high cycle. Read/write collision on the same address -> old value returned.
- RX_PARITY_EN defined:
  - 0xA5 with parity bit 0 -> word_valid at SL+10;
  - parity bit 1 -> err_parity=1, no word_valid, bank unchanged.
